pipe_hazard_ctrl: RTL and testbench

Hazard and pipeline-sequencing controller for the five-stage MIPS core. Each cycle it decides whether the D/E boundary takes a new instruction, freezes the front end while inserting a bubble into E, or yields to an exception flush. It owns the multiply/divide-unit (MDU) busy timer, the EPC-ordering interlock for `eret`, and a stall-cycle performance counter. Its `stall` output drives PC hold, F/D hold and the D/E register's bubble input. `M_REQ` drives the flush input of every pipeline register directly and does not pass through this block.

---
 rtl/pipe_hazard_ctrl_if.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 35 +++
 tb/tb_pipe_hazard_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode/execute/memory hazard inputs and stall outputs of the hazard controller
interface pipe_hazard_ctrl_if;
  logic [4:0] D_rs, D_rt, E_waddr, M_waddr;
  logic [1:0] D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
  logic D_md_use, E_md_start, E_md_is_div, D_eret, E_mtc0_epc, M_mtc0_epc, M_REQ;
  logic stall, md_busy;
  logic [31:0] stall_cnt;
  modport master(
    output D_rs, D_rt, E_waddr, M_waddr, D_tuse_rs, D_tuse_rt, E_tnew, M_tnew,
           D_md_use, E_md_start, E_md_is_div, D_eret, E_mtc0_epc, M_mtc0_epc, M_REQ,
    input stall, md_busy, stall_cnt
  );
  modport slave(
    input D_rs, D_rt, E_waddr, M_waddr, D_tuse_rs, D_tuse_rt, E_tnew, M_tnew,
          D_md_use, E_md_start, E_md_is_div, D_eret, E_mtc0_epc, M_mtc0_epc, M_REQ,
    output stall, md_busy, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: D/E stall decision, MDU busy timer and saturating stall-cycle counter
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.slave h
);
  logic [3:0] md_cnt;
  logic [31:0] stall_cnt;
  logic busy, stall_rs, stall_rt, stall_md, stall_epc, stall;
  assign busy = md_cnt != 4'd0;
  assign stall_rs = (h.D_rs != 5'd0) && (h.D_tuse_rs != 2'd3) &&
                    ((h.E_waddr == h.D_rs && h.E_tnew > h.D_tuse_rs) ||
                     (h.M_waddr == h.D_rs && h.M_tnew > h.D_tuse_rs));
  assign stall_rt = (h.D_rt != 5'd0) && (h.D_tuse_rt != 2'd3) &&
                    ((h.E_waddr == h.D_rt && h.E_tnew > h.D_tuse_rt) ||
                     (h.M_waddr == h.D_rt && h.M_tnew > h.D_tuse_rt));
  assign stall_md = h.D_md_use && (busy || h.E_md_start);
  assign stall_epc = h.D_eret && (h.E_mtc0_epc || h.M_mtc0_epc);
  // the exception flush always overrides a hazard freeze
  assign stall = (stall_rs || stall_rt || stall_md || stall_epc) && !h.M_REQ;
  assign h.stall = stall;
  assign h.md_busy = busy;
  assign h.stall_cnt = stall_cnt;
  // a running count is never cleared by M_REQ: its issuing instruction has committed
  always_ff @(posedge clk or negedge rst)
    if (!rst) md_cnt <= 4'd0;
    else if (busy) md_cnt <= md_cnt - 4'd1;
    else if (h.E_md_start && !h.M_REQ) md_cnt <= h.E_md_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_cnt <= 32'd0;
    else if (stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench with a cycle-indexed reference model of the hazard controller
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if h();
  pipe_hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut(.clk(clk), .rst(rst), .h(h));
  typedef struct packed {logic stall; logic busy; logic [31:0] cnt;} resp_t;
  resp_t q[$];
  int checks = 0;
  int fails = 0;
  longint cyc = 0;
  longint busy_until = 0;
  longint nstall = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic set(input int rs, rt, tu_rs, tu_rt, ew, et, mw, mt,
                     input bit mduse, start, isdiv, eret, emtc, mmtc, mreq);
    h.D_rs = 5'(rs); h.D_rt = 5'(rt); h.D_tuse_rs = 2'(tu_rs); h.D_tuse_rt = 2'(tu_rt);
    h.E_waddr = 5'(ew); h.E_tnew = 2'(et); h.M_waddr = 5'(mw); h.M_tnew = 2'(mt);
    h.D_md_use = mduse; h.E_md_start = start; h.E_md_is_div = isdiv; h.D_eret = eret;
    h.E_mtc0_epc = emtc; h.M_mtc0_epc = mmtc; h.M_REQ = mreq;
  endtask
  task automatic idle(input bit mduse);
    set(0, 0, 3, 3, 0, 0, 0, 0, mduse, 0, 0, 0, 0, 0, 0);
  endtask
  function automatic bit ref_stall(input bit busy);
    logic [4:0] src[2];
    logic [4:0] dst[2];
    logic [1:0] tuse[2];
    logic [1:0] tnew[2];
    bit haz;
    src = '{h.D_rs, h.D_rt};
    tuse = '{h.D_tuse_rs, h.D_tuse_rt};
    dst = '{h.E_waddr, h.M_waddr};
    tnew = '{h.E_tnew, h.M_tnew};
    haz = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (src[i] != 0 && tuse[i] != 3 && dst[j] == src[i] && tnew[j] > tuse[i]) haz = 1;
    if (h.D_md_use && (busy || h.E_md_start)) haz = 1;
    if (h.D_eret && (h.E_mtc0_epc || h.M_mtc0_epc)) haz = 1;
    return haz && !h.M_REQ;
  endfunction
  // called at a falling edge with inputs applied; returns at the next falling edge
  task automatic step();
    resp_t e;
    bit busy, acc;
    longint n;
    #1;
    busy = cyc < busy_until;
    e.stall = ref_stall(busy);
    e.busy = busy;
    e.cnt = nstall > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : 32'(nstall);
    q.push_back(e);
    acc = h.E_md_start && !h.M_REQ && !busy;
    n = h.E_md_is_div ? 10 : 5;
    @(posedge clk);
    if (acc) busy_until = cyc + 1 + n;
    if (e.stall) nstall++;
    cyc++;
    @(negedge clk);
  endtask
  initial forever begin
    resp_t e;
    @(negedge clk);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("stall", 32'(h.stall), 32'(e.stall));
      check("md_busy", 32'(h.md_busy), 32'(e.busy));
      check("stall_cnt", h.stall_cnt, e.cnt);
    end
  end
  initial begin
    idle(0);
    repeat (2) @(negedge clk);
    #1;
    check("reset_busy", 32'(h.md_busy), 0);
    check("reset_cnt", h.stall_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    set(8, 0, 1, 3, 8, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    set(8, 0, 1, 3, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0); step();
    set(0, 0, 0, 3, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    set(0, 5, 3, 0, 5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0); step();
    set(9, 0, 3, 3, 9, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    set(0, 0, 3, 3, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0); step();
    idle(1); repeat (12) step();
    set(0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); step();
    idle(0); repeat (7) step();
    set(0, 0, 3, 3, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1); step();
    idle(1); step();
    idle(0);
    set(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0); step();
    set(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0); step();
    set(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); step();
    set(0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    idle(0); repeat (9) step();
    set(0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0); step();
    idle(0); repeat (3) step();
    for (int i = 0; i < 600; i++) begin
      set($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 11) == 0);
      step();
    end
    idle(0); repeat (12) step();
    set(0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); step();
    idle(0); repeat (3) step();
    #3;
    check("pre_reset_busy", 32'(h.md_busy), 1);
    rst = 1'b0;
    #1;
    check("async_busy", 32'(h.md_busy), 0);
    check("async_cnt", h.stall_cnt, 0);
    busy_until = 0;
    nstall = 0;
    @(negedge clk);
    check("held_reset_busy", 32'(h.md_busy), 0);
    rst = 1'b1;
    set(3, 0, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    for (int i = 0; i < 40; i++) begin
      set($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0);
      step();
    end
    #3;
    check("queue_drained", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
